// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions: cycle/burst type codes and the slave FSM encoding.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_BURST  = 2'b10
    } wb_state_t;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next word index of a Wishbone incrementing burst for each BTE mode.
// The index carries one extra MSB so a linear burst running off the top is visible as ovf.
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic [ADDR_BITS:0] baddr,
    input  logic [1:0]         bte,
    output logic [ADDR_BITS:0] next_addr,
    output logic               ovf
);

    logic [ADDR_BITS:0] inc_s;

    assign inc_s = baddr + {{ADDR_BITS{1'b0}}, 1'b1};

    // Wrap modes replace only the low bits; the upper bits stay as they are.
    always_comb begin
        next_addr = baddr;
        case (bte)
            BTE_LINEAR: next_addr = inc_s;
            BTE_WRAP4:  next_addr = {baddr[ADDR_BITS:2], inc_s[1:0]};
            BTE_WRAP8:  next_addr = {baddr[ADDR_BITS:3], inc_s[2:0]};
            BTE_WRAP16: next_addr = {baddr[ADDR_BITS:4], inc_s[3:0]};
            default:    next_addr = inc_s;
        endcase
    end

    assign ovf = next_addr[ADDR_BITS];

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 slave in front of a single-port byte-writable synchronous RAM.
// Classic cycles answer after one wait cycle; incrementing bursts stream one beat per clock.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int DW            = 32,
    parameter int AW            = 32,
    parameter int MEM_WORDS     = 1024,
    parameter int MEM_ADDR_BITS = $clog2(MEM_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] wbs_adr_i,
    input  logic [DW-1:0] wbs_dat_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic          wbs_we_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic [2:0]    wbs_cti_i,
    input  logic [1:0]    wbs_bte_i,
    output logic [DW-1:0] wbs_dat_o,
    output logic          wbs_ack_o,
    output logic          wbs_err_o,
    output logic          wbs_rty_o
);

    wb_state_t state_r;
    wb_state_t state_nxt_s;

    logic [MEM_ADDR_BITS:0]   baddr_r;
    logic [MEM_ADDR_BITS:0]   baddr_nxt_s;
    logic [MEM_ADDR_BITS:0]   next_addr_s;
    logic                     next_ovf_s;
    logic                     oor_r;
    logic                     oor_nxt_s;
    logic                     ack_r;
    logic                     ack_nxt_s;
    logic                     err_r;
    logic                     err_nxt_s;
    logic [DW-1:0]            dat_r;

    logic                     req_s;
    logic                     adr_oor_s;
    logic [MEM_ADDR_BITS-1:0] adr_idx_s;
    logic                     beat_done_s;
    logic                     resp_s;
    logic                     bad_s;
    logic                     rd_en_s;
    logic [MEM_ADDR_BITS-1:0] rd_addr_s;
    logic                     wr_en_s;
    logic [MEM_ADDR_BITS-1:0] wr_addr_s;
    logic                     unused_s;

    logic [DW-1:0] mem_r [MEM_WORDS];

    assign req_s       = wbs_cyc_i & wbs_stb_i;
    assign adr_oor_s   = |wbs_adr_i[AW-1:MEM_ADDR_BITS+2];
    assign adr_idx_s   = wbs_adr_i[MEM_ADDR_BITS+1:2];
    assign resp_s      = ack_r | err_r;
    assign beat_done_s = resp_s & req_s;
    assign bad_s       = oor_r | baddr_r[MEM_ADDR_BITS];
    assign wr_addr_s   = baddr_r[MEM_ADDR_BITS-1:0];
    assign unused_s    = ^wbs_adr_i[1:0];

    wb_burst_addr_gen #(
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_addr_gen (
        .baddr     (baddr_r),
        .bte       (wbs_bte_i),
        .next_addr (next_addr_s),
        .ovf       (next_ovf_s)
    );

    // Next-state, response and RAM-port control.
    always_comb begin
        state_nxt_s = state_r;
        baddr_nxt_s = baddr_r;
        oor_nxt_s   = oor_r;
        ack_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        rd_en_s     = 1'b0;
        rd_addr_s   = baddr_r[MEM_ADDR_BITS-1:0];
        wr_en_s     = 1'b0;

        if (!wbs_cyc_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        baddr_nxt_s = {1'b0, adr_idx_s};
                        oor_nxt_s   = adr_oor_s;
                        rd_en_s     = 1'b1;
                        rd_addr_s   = adr_idx_s;
                        ack_nxt_s   = ~adr_oor_s;
                        err_nxt_s   = adr_oor_s;
                        state_nxt_s = (wbs_cti_i == CTI_INCR) ? ST_BURST : ST_SINGLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end

                ST_SINGLE: begin
                    wr_en_s     = ack_r & req_s & wbs_we_i;
                    state_nxt_s = ST_IDLE;
                end

                ST_BURST: begin
                    if (beat_done_s) begin
                        wr_en_s = ack_r & wbs_we_i;
                        if (err_r || (wbs_cti_i == CTI_EOB)) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            // Prefetch the following beat so it can be acked next cycle.
                            baddr_nxt_s = next_addr_s;
                            rd_en_s     = 1'b1;
                            rd_addr_s   = next_addr_s[MEM_ADDR_BITS-1:0];
                            ack_nxt_s   = ~(oor_r | next_ovf_s);
                            err_nxt_s   = oor_r | next_ovf_s;
                        end
                    end else if (req_s && !resp_s) begin
                        rd_en_s   = 1'b1;
                        ack_nxt_s = ~bad_s;
                        err_nxt_s = bad_s;
                    end else begin
                        state_nxt_s = ST_BURST;
                    end
                end

                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Control and response registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            baddr_r <= '0;
            oor_r   <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            baddr_r <= baddr_nxt_s;
            oor_r   <= oor_nxt_s;
            ack_r   <= ack_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Registered read port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dat_r <= '0;
        end else if (rd_en_s) begin
            dat_r <= mem_r[rd_addr_s];
        end
    end

    // Byte-lane write port; contents intentionally survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wbs_sel_i[i]) begin
                    mem_r[wr_addr_s][8*i +: 8] <= wbs_dat_i[8*i +: 8];
                end
            end
        end
    end

    assign wbs_dat_o = dat_r;
    assign wbs_ack_o = ack_r;
    assign wbs_err_o = err_r;
    assign wbs_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: the driver queues the exact cycle and content of
// every ack/err it expects, a monitor matches each asserted ack/err against that queue.
module tb_wb_sram_slave;
    import wb_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] dat;
        int          at;
    } resp_t;

    resp_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    logic [31:0] bdat [8];

    wb_sram_slave #(
        .DW (32), .AW (32), .MEM_WORDS (1024)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cti_i (wbs_cti_i),
        .wbs_bte_i (wbs_bte_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbs_err_o (wbs_err_o),
        .wbs_rty_o (wbs_rty_o)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                       input logic [1:0] bt);
        wbs_cyc_i = c;
        wbs_stb_i = s;
        wbs_we_i  = w;
        wbs_adr_i = a;
        wbs_dat_i = d;
        wbs_sel_i = sl;
        wbs_cti_i = ct;
        wbs_bte_i = bt;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    endtask

    task automatic expect_resp(input bit e, input bit chk, input logic [31:0] d, input int at);
        exp_q.push_back('{e, chk, d, at});
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Classic cycle: response one cycle after the strobe, then one idle cycle.
    task automatic classic(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sl, input bit e, input logic [31:0] rd);
        bus(1'b1, 1'b1, w, a, d, sl, CTI_CLASSIC, BTE_LINEAR);
        expect_resp(e, !w && !e, rd, cyc_cnt + 1);
        step();
        step();
        idle();
    endtask

    // Back-to-back burst of n beats; bdat holds write data or expected read data.
    task automatic burst(input bit w, input logic [31:0] a, input logic [1:0] bt, input int n);
        int c;
        c = cyc_cnt;
        bus(1'b1, 1'b1, w, a, bdat[0], 4'hF, (n == 1) ? CTI_EOB : CTI_INCR, bt);
        for (int i = 0; i < n; i++) begin
            expect_resp(1'b0, !w, bdat[i], c + 1 + i);
            step();
            wbs_dat_i = bdat[i];
            wbs_cti_i = (i == n - 1) ? CTI_EOB : CTI_INCR;
        end
        step();
        idle();
    endtask

    task automatic monitor();
        resp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && (wbs_ack_o || wbs_err_o)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: cycle %0d ack=%b err=%b, expected no response",
                             cyc_cnt, wbs_ack_o, wbs_err_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at != cyc_cnt || wbs_err_o != e.err || wbs_ack_o == wbs_err_o ||
                        (e.chk && wbs_dat_o !== e.dat)) begin
                        errors++;
                        $display("FAIL resp: cycle %0d ack=%b err=%b dat=%h, expected cycle %0d err=%b dat=%h%s",
                                 cyc_cnt, wbs_ack_o, wbs_err_o, wbs_dat_o, e.at, e.err, e.dat,
                                 e.chk ? "" : " (data unchecked)");
                    end
                end
            end
        end
    endtask

    initial begin
        int c;
        fork
            monitor();
        join_none

        i_rst = 1'b1;
        idle();
        step();
        step();
        check("reset_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("reset_err", {31'h0, wbs_err_o}, 32'h0);
        check("reset_dat", wbs_dat_o, 32'h0);
        check("reset_rty", {31'h0, wbs_rty_o}, 32'h0);
        #2 i_rst = 1'b0;
        step();

        // Preload words 0..3 with their own index.
        for (int n = 0; n < 4; n++) begin
            classic(1'b1, 32'(n * 4), 32'(n), 4'hF, 1'b0, 32'h0);
        end

        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
        classic(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0, 32'h0);
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADAAEF);
        classic(1'b1, 32'h10, 32'h11000022, 4'b1001, 1'b0, 32'h0);
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h11ADAA22);

        bdat[0] = 32'd3; bdat[1] = 32'd0; bdat[2] = 32'd1; bdat[3] = 32'd2;
        burst(1'b0, 32'h0C, BTE_WRAP4, 4);

        // Linear write burst with the strobe dropped for two cycles after beat 1.
        c = cyc_cnt;
        bus(1'b1, 1'b1, 1'b1, 32'h100, 32'hA0, 4'hF, CTI_INCR, BTE_LINEAR);
        expect_resp(1'b0, 1'b0, 32'h0, c + 1);
        step();
        expect_resp(1'b0, 1'b0, 32'h0, c + 2);
        step();
        wbs_dat_i = 32'hA1;
        // Beat 2's ack is already registered when the master stalls; the master ignores it.
        expect_resp(1'b0, 1'b0, 32'h0, c + 3);
        step();
        wbs_stb_i = 1'b0;
        step();
        step();
        wbs_stb_i = 1'b1;
        wbs_dat_i = 32'hA2;
        expect_resp(1'b0, 1'b0, 32'h0, c + 6);
        step();
        expect_resp(1'b0, 1'b0, 32'h0, c + 7);
        step();
        wbs_dat_i = 32'hA3;
        wbs_cti_i = CTI_EOB;
        step();
        idle();
        for (int n = 0; n < 4; n++) begin
            classic(1'b0, 32'h100 + 32'(n * 4), 32'h0, 4'hF, 1'b0, 32'hA0 + 32'(n));
        end

        classic(1'b0, 32'h1000, 32'h0, 4'hF, 1'b1, 32'h0);

        // Linear burst off the top of memory: first beat acks, second errors.
        c = cyc_cnt;
        bus(1'b1, 1'b1, 1'b1, 32'hFFC, 32'h11111111, 4'hF, CTI_INCR, BTE_LINEAR);
        expect_resp(1'b0, 1'b0, 32'h0, c + 1);
        step();
        expect_resp(1'b1, 1'b0, 32'h0, c + 2);
        step();
        wbs_dat_i = 32'h22222222;
        step();
        idle();
        classic(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h0);
        classic(1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, 32'h11111111);

        // Reset while beat 2 of a write burst is being acked.
        classic(1'b1, 32'h200, 32'h66666666, 4'hF, 1'b0, 32'h0);
        classic(1'b1, 32'h204, 32'h55555555, 4'hF, 1'b0, 32'h0);
        c = cyc_cnt;
        bus(1'b1, 1'b1, 1'b1, 32'h200, 32'hC0C0C0C0, 4'hF, CTI_INCR, BTE_LINEAR);
        expect_resp(1'b0, 1'b0, 32'h0, c + 1);
        step();
        step();
        wbs_dat_i = 32'hC1C1C1C1;
        #2 i_rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("rst_mid_err", {31'h0, wbs_err_o}, 32'h0);
        check("rst_mid_dat", wbs_dat_o, 32'h0);
        idle();
        step();
        #2 i_rst = 1'b0;
        step();
        classic(1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 32'hC0C0C0C0);
        classic(1'b0, 32'h204, 32'h0, 4'hF, 1'b0, 32'h55555555);

        step();
        step();
        check("pending_resp", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
